// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the ALU
// command issuer and anything that talks to the attached ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MAX = 3'b010;
  localparam logic [2:0] OP_LE  = 3'b011;
  localparam logic [2:0] OP_AVG = 3'b100;
  localparam logic [2:0] OP_SQR = 3'b101;
  localparam logic [2:0] OP_ABS = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  localparam int FLG_SIGN   = 0;
  localparam int FLG_OVF    = 1;
  localparam int FLG_STATUS = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU and response signal bundle of the ALU command issuer.
// slave: issuer side; master: command source / ALU / consumer side.
interface alu_cmd_issuer_if #(
  parameter int N = 5
);

  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [N-1:0] cmd_a;
  logic [N-1:0] cmd_b;

  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [2:0]   alu_op;
  logic [N-1:0] alu_result;
  logic         alu_sign;
  logic         alu_overflow;
  logic         alu_status;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_result;
  logic [2:0]   rsp_flags;
  logic [2:0]   rsp_op;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    input  alu_result, alu_sign, alu_overflow, alu_status,
    input  rsp_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    output rsp_valid, rsp_result, rsp_flags, rsp_op
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    output alu_result, alu_sign, alu_overflow, alu_status,
    output rsp_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_result, rsp_flags, rsp_op
  );

endinterface

// File: rtl/alu_rsp_fifo.sv
// In-order response FIFO; head is read combinationally from storage.
// Storage is not reset: head is meaningless while empty.
module alu_rsp_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= din;
  end

  assign head  = mem[rd_q];
  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/alu_cmd_issuer.sv
// Registers one command onto the ALU, captures its outputs a cycle
// later and returns them in order through a buffered response channel.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int N     = 5,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_cmd_issuer_if.slave        bus,
  output logic                   busy,
  output logic [7:0]             ovf_count
);

  localparam int W = N + 6;

  state_t       state_q;
  state_t       state_d;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [2:0]   op_q;
  logic [7:0]   ovf_q;

  logic         ready;
  logic         load;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  logic [2:0]   flags;
  logic [W-1:0] head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    load    = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = !full;
        if (bus.cmd_valid && !full) begin
          load    = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        push    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Operands hold their last value between commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (load) begin
      a_q  <= bus.cmd_a;
      b_q  <= bus.cmd_b;
      op_q <= bus.cmd_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          ovf_q <= '0;
    else if (push && bus.alu_overflow) ovf_q <= sat_inc(ovf_q);
  end

  always_comb begin
    flags             = '0;
    flags[FLG_SIGN]   = bus.alu_sign;
    flags[FLG_OVF]    = bus.alu_overflow;
    flags[FLG_STATUS] = bus.alu_status;
  end

  alu_rsp_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({op_q, flags, bus.alu_result}),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign pop            = !empty && bus.rsp_ready;
  assign bus.cmd_ready  = ready;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
  assign bus.rsp_valid  = !empty;
  assign bus.rsp_result = head[N-1:0];
  assign bus.rsp_flags  = head[N+2:N];
  assign bus.rsp_op     = head[N+5:N+3];
  assign busy           = (state_q != IDLE) || !empty;
  assign ovf_count      = ovf_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomized and directed bench for alu_cmd_issuer with a behavioural
// ALU attached and an in-order queue model of the response channel.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int N     = 5;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [7:0] ovf_count;

  alu_cmd_issuer_if #(.N(N)) bus ();

  alu_cmd_issuer #(
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .ovf_count (ovf_count)
  );

  int vectors = 0;
  int errors  = 0;

  // returns {status, overflow, sign, result}
  function automatic logic [N+2:0] alu_ref(input logic [2:0] op,
                                           input logic [N-1:0] a,
                                           input logic [N-1:0] b);
    int   sa, sb, v;
    logic st, ov;
    sa = int'($signed(a));
    sb = int'($signed(b));
    st = 1'b0;
    case (op)
      OP_ADD:  v = sa + sb;
      OP_SUB:  v = sa - sb;
      OP_MAX:  v = (sa > sb) ? sa : sb;
      OP_LE: begin
        v  = (sa <= sb) ? 1 : 0;
        st = (sa <= sb);
      end
      OP_AVG:  v = (sa + sb) >>> 1;
      OP_SQR:  v = sa * sa;
      OP_ABS:  v = (sa < 0) ? -sa : sa;
      default: v = sa >>> 1;
    endcase
    ov = (v > (1 << (N - 1)) - 1) || (v < -(1 << (N - 1)));
    return {st, ov, v[N-1], v[N-1:0]};
  endfunction

  assign {bus.alu_status, bus.alu_overflow, bus.alu_sign, bus.alu_result} =
    alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue of pending responses plus one in-flight command.
  logic [N+5:0] q [$];
  logic         pend;
  logic [N+5:0] pend_e;
  int           ovf_m;
  logic [N-1:0] la, lb;
  logic [2:0]   lop;
  logic         chk_en;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      pend   = 1'b0;
      pend_e = '0;
      ovf_m  = 0;
      la     = '0;
      lb     = '0;
      lop    = '0;
    end else begin : step_model
      logic acc, pp;
      acc = bus.cmd_valid && !pend && (q.size() < DEPTH);
      pp  = bus.rsp_ready && (q.size() > 0);
      if (pp) void'(q.pop_front());
      if (pend) begin
        q.push_back(pend_e);
        if (pend_e[N+1] && ovf_m < 255) ovf_m++;
      end
      pend = acc;
      if (acc) begin
        pend_e = {bus.cmd_op, alu_ref(bus.cmd_op, bus.cmd_a, bus.cmd_b)};
        la     = bus.cmd_a;
        lb     = bus.cmd_b;
        lop    = bus.cmd_op;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("cmd_ready", bus.cmd_ready, !pend && (q.size() < DEPTH));
      check("rsp_valid", bus.rsp_valid, q.size() > 0);
      check("busy", busy, pend || (q.size() > 0));
      check("ovf_count", ovf_count, ovf_m);
      check("alu_a", bus.alu_a, la);
      check("alu_b", bus.alu_b, lb);
      check("alu_op", bus.alu_op, lop);
      if (q.size() > 0) begin
        check("rsp_result", bus.rsp_result, q[0][N-1:0]);
        check("rsp_flags", bus.rsp_flags, q[0][N+2:N]);
        check("rsp_op", bus.rsp_op, q[0][N+5:N+3]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [2:0] op, input logic [N-1:0] a,
                      input logic [N-1:0] b);
    logic acc;
    acc           = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    for (int n = 0; n < 200; n++) begin
      acc = bus.cmd_ready;
      step();
      if (acc) break;
    end
    bus.cmd_valid = 1'b0;
    if (!acc) check("cmd accept timeout", acc, 1);
  endtask

  task automatic pop1();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200 && busy; n++) step();
    check("drain busy", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  logic rnd_done;

  initial begin
    chk_en        = 1'b0;
    rnd_done      = 1'b0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) step();
    check("reset alu_a", bus.alu_a, 0);
    check("reset ovf_count", ovf_count, 0);
    check("reset rsp_valid", bus.rsp_valid, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;
    #1;
    check("reset cmd_ready", bus.cmd_ready, 1);
    chk_en = 1'b1;
    step();

    send(OP_ADD, 5'd7, 5'd9);
    step();
    check("add rsp_valid", bus.rsp_valid, 1);
    check("add result", bus.rsp_result, 5'b10000);
    check("add flags", bus.rsp_flags, 3'b011);
    check("add ovf_count", ovf_count, 1);
    pop1();

    send(OP_SUB, 5'd3, 5'd5);
    step();
    check("sub result", bus.rsp_result, 5'b11110);
    check("sub flags", bus.rsp_flags, 3'b001);
    check("sub ovf_count", ovf_count, 1);
    pop1();

    send(OP_LE, 5'b11101, 5'd2);
    step();
    check("le result", bus.rsp_result, 5'b00001);
    check("le flags", bus.rsp_flags, 3'b100);
    check("le op", bus.rsp_op, 3'b011);
    pop1();

    fork
      begin
        for (int i = 0; i < 5; i++)
          send(3'(i), 5'(i), 5'(2 * i + 1));
      end
      begin
        repeat (20) step();
        check("bp cmd_ready held", bus.cmd_ready, 0);
        check("bp alu_a fourth", bus.alu_a, 3);
        check("bp rsp_valid", bus.rsp_valid, 1);
        bus.rsp_ready = 1'b1;
      end
    join
    wait_idle();

    send(OP_ADD, 5'd7, 5'd9);
    #1;
    rst = 1'b1;
    #1;
    check("rst alu_a", bus.alu_a, 0);
    check("rst alu_b", bus.alu_b, 0);
    check("rst alu_op", bus.alu_op, 0);
    check("rst ovf_count", ovf_count, 0);
    check("rst rsp_valid", bus.rsp_valid, 0);
    check("rst busy", busy, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst cmd_ready", bus.cmd_ready, 1);
    repeat (4) begin
      step();
      check("rst no rsp", bus.rsp_valid, 0);
    end

    bus.rsp_ready = 1'b1;
    repeat (300) send(OP_ADD, 5'd7, 5'd9);
    repeat (2) step();
    check("sat ovf_count", ovf_count, 255);
    send(OP_ADD, 5'd7, 5'd9);
    repeat (2) step();
    check("sat hold", ovf_count, 255);

    fork
      begin
        repeat (400) begin
          repeat ($urandom_range(0, 2)) step();
          send(3'($urandom), 5'($urandom), 5'($urandom));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          if ($urandom_range(0, 7) == 0)
            bus.rsp_ready = 1'b0;
          else
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
          step();
        end
      end
    join
    bus.rsp_ready = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
